// File: rtl/alu_issue_stage.sv
// ALU issue stage: an output register plus a skid register, with a registered dec_ready.
// Define ISSUE_FWD_EN to enable writeback forwarding at capture and snoop forwarding on held entries.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int FN_W   = 4,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [FN_W-1:0]   dec_alu_fn,
    input  logic [REG_AW-1:0] dec_rs1_addr,
    input  logic [REG_AW-1:0] dec_rs2_addr,
    input  logic [XLEN-1:0]   dec_rs1_val,
    input  logic [XLEN-1:0]   dec_rs2_val,
    input  logic [REG_AW-1:0] dec_rd_addr,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [XLEN-1:0]   dec_pc,
    input  logic              dec_use_imm,
    input  logic              dec_use_pc,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   operandA,
    output logic [XLEN-1:0]   operandB,
    output logic [FN_W-1:0]   alu_fn,
    output logic [REG_AW-1:0] ex_rd_addr
);

    typedef struct packed {
        logic [FN_W-1:0]   fn;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1_addr;
        logic [XLEN-1:0]   rs1_val;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic              use_imm;
        logic              use_pc;
    } entry_t;

    entry_t r_out, r_skid;
    logic   r_out_v, r_skid_v, r_dec_ready;
    entry_t w_dec_e, w_out_s, w_skid_s;
    logic   w_acc, w_cons;

    assign w_acc  = dec_valid & r_dec_ready;
    assign w_cons = r_out_v & ex_ready;

`ifdef ISSUE_FWD_EN
    // x0 reads are never forwarded
    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] addr,
                                            input logic [XLEN-1:0]   val);
        if (wb_we && (wb_rd == addr) && (addr != '0))
            return wb_data;
        return val;
    endfunction
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

    always_comb begin
        w_dec_e          = '0;
        w_dec_e.fn       = dec_alu_fn;
        w_dec_e.rd       = dec_rd_addr;
        w_dec_e.rs1_addr = dec_rs1_addr;
        w_dec_e.rs1_val  = dec_rs1_val;
        w_dec_e.rs2_addr = dec_rs2_addr;
        w_dec_e.rs2_val  = dec_rs2_val;
        w_dec_e.imm      = dec_imm;
        w_dec_e.pc       = dec_pc;
        w_dec_e.use_imm  = dec_use_imm;
        w_dec_e.use_pc   = dec_use_pc;
        w_out_s          = r_out;
        w_skid_s         = r_skid;
`ifdef ISSUE_FWD_EN
        w_dec_e.rs1_val = fwd(dec_rs1_addr, dec_rs1_val);
        w_dec_e.rs2_val = fwd(dec_rs2_addr, dec_rs2_val);
        if (r_out_v) begin
            w_out_s.rs1_val = fwd(r_out.rs1_addr, r_out.rs1_val);
            w_out_s.rs2_val = fwd(r_out.rs2_addr, r_out.rs2_val);
        end
        if (r_skid_v) begin
            w_skid_s.rs1_val = fwd(r_skid.rs1_addr, r_skid.rs1_val);
            w_skid_s.rs2_val = fwd(r_skid.rs2_addr, r_skid.rs2_val);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_skid      <= '0;
            r_out_v     <= 1'b0;
            r_skid_v    <= 1'b0;
            r_dec_ready <= 1'b1;
        end else if (flush) begin
            r_out_v     <= 1'b0;
            r_skid_v    <= 1'b0;
            r_dec_ready <= 1'b1;
        end else if (!r_out_v || w_cons) begin
            // skid can only be full while dec_ready is low, so it wins over an accept
            if (r_skid_v) begin
                r_out    <= w_skid_s;
                r_out_v  <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_acc) begin
                r_out   <= w_dec_e;
                r_out_v <= 1'b1;
            end else begin
                r_out_v <= 1'b0;
            end
            r_dec_ready <= 1'b1;
        end else begin
            r_out <= w_out_s;
            if (w_acc) begin
                r_skid   <= w_dec_e;
                r_skid_v <= 1'b1;
            end else begin
                r_skid <= w_skid_s;
            end
            r_dec_ready <= ~(r_skid_v | w_acc);
        end
    end

    assign dec_ready  = r_dec_ready;
    assign ex_valid   = r_out_v;
    assign operandA   = r_out.use_pc  ? r_out.pc  : r_out.rs1_val;
    assign operandB   = r_out.use_imm ? r_out.imm : r_out.rs2_val;
    assign alu_fn     = r_out.fn;
    assign ex_rd_addr = r_out.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random checks of alu_issue_stage against a two-deep queue model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, dec_valid, dec_ready;
    logic [3:0]  dec_alu_fn;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm, dec_pc;
    logic        dec_use_imm, dec_use_pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] operandA, operandB;
    logic [3:0]  alu_fn;
    logic [4:0]  ex_rd_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_alu_fn(dec_alu_fn),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
        .dec_rd_addr(dec_rd_addr), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_use_imm(dec_use_imm), .dec_use_pc(dec_use_pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .operandA(operandA), .operandB(operandB), .alu_fn(alu_fn), .ex_rd_addr(ex_rd_addr)
    );

    typedef struct {
        logic [3:0]  fn;
        logic [4:0]  rd, a1, a2;
        logic [31:0] v1, v2, imm, pc;
        logic        ui, up;
    } ent_t;

    ent_t q[$];

`ifdef ISSUE_FWD_EN
    localparam logic [31:0] EXP_CAP   = 32'hDEAD;
    localparam logic [31:0] EXP_SNOOP = 32'hBEEF;
`else
    localparam logic [31:0] EXP_CAP   = 32'h1;
    localparam logic [31:0] EXP_SNOOP = 32'h1;
`endif

    function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] v);
`ifdef ISSUE_FWD_EN
        if (wb_we && a != 5'd0 && wb_rd == a) return wb_data;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, q.size() > 0});
        chk("dec_ready", {31'd0, dec_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("operandA", operandA, q[0].up ? q[0].pc : q[0].v1);
            chk("operandB", operandB, q[0].ui ? q[0].imm : q[0].v2);
            chk("alu_fn", {28'd0, alu_fn}, {28'd0, q[0].fn});
            chk("ex_rd", {27'd0, ex_rd_addr}, {27'd0, q[0].rd});
        end
    endtask

    // Model step: snoop held entries, then flush or pop/push.
    task automatic model_step();
        ent_t e;
        bit acc, cons;
        acc  = dec_valid && (q.size() < 2);
        cons = ex_ready && (q.size() > 0);
        foreach (q[i]) begin
            q[i].v1 = mfwd(q[i].a1, q[i].v1);
            q[i].v2 = mfwd(q[i].a2, q[i].v2);
        end
        e.fn = dec_alu_fn; e.rd = dec_rd_addr; e.a1 = dec_rs1_addr; e.a2 = dec_rs2_addr;
        e.v1 = mfwd(dec_rs1_addr, dec_rs1_val); e.v2 = mfwd(dec_rs2_addr, dec_rs2_val);
        e.imm = dec_imm; e.pc = dec_pc; e.ui = dec_use_imm; e.up = dec_use_pc;
        if (flush) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic tick();
        check_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_dec(input logic [3:0] fn, input logic [4:0] rd,
                           input logic [4:0] a1, input logic [31:0] v1,
                           input logic [4:0] a2, input logic [31:0] v2,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic ui, input logic up);
        dec_valid = 1'b1; dec_alu_fn = fn; dec_rd_addr = rd;
        dec_rs1_addr = a1; dec_rs1_val = v1; dec_rs2_addr = a2; dec_rs2_val = v2;
        dec_imm = imm; dec_pc = pc; dec_use_imm = ui; dec_use_pc = up;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
        chk("rst_opA", operandA, 32'd0);
        chk("rst_opB", operandB, 32'd0);
        chk("rst_fn", {28'd0, alu_fn}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd_addr}, 32'd0);

        // single instruction
        ex_ready = 1'b1;
        set_dec(0, 1, 1, 32'd5, 2, 32'd7, 0, 0, 0, 0);
        tick();
        dec_valid = 1'b0;
        chk("single_valid", {31'd0, ex_valid}, 32'd1);
        chk("single_opA", operandA, 32'd5);
        chk("single_opB", operandB, 32'd7);
        chk("single_ready", {31'd0, dec_ready}, 32'd1);
        tick();

        // back-pressure: A held, B in skid, C refused until release
        ex_ready = 1'b0;
        set_dec(1, 4, 5, 32'h11, 6, 32'h1A, 0, 0, 0, 0); tick();
        set_dec(2, 5, 5, 32'h22, 6, 32'h2A, 0, 0, 0, 0); tick();
        set_dec(3, 6, 5, 32'h33, 6, 32'h3A, 0, 0, 0, 0); tick();
        chk("bp_ready_low", {31'd0, dec_ready}, 32'd0);
        chk("bp_holdA", operandA, 32'h11);
        tick();
        chk("bp_stillA", operandA, 32'h11);
        ex_ready = 1'b1;
        tick();
        chk("bp_outB", operandA, 32'h22);
        tick();
        dec_valid = 1'b0;
        chk("bp_outC", operandA, 32'h33);
        tick();
        chk("bp_empty", {31'd0, ex_valid}, 32'd0);

        // capture then snoop forwarding on x3
        ex_ready = 1'b0;
        set_dec(0, 7, 3, 32'd1, 4, 32'd2, 0, 0, 0, 0);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        tick();
        dec_valid = 1'b0; wb_we = 1'b0;
        chk("fwd_capture", operandA, EXP_CAP);
        wb_we = 1'b1; wb_data = 32'hBEEF;
        tick();
        wb_we = 1'b0;
        chk("fwd_snoop", operandA, EXP_SNOOP);
        ex_ready = 1'b1;
        tick();

        // x0 is never forwarded
        set_dec(0, 1, 1, 32'd3, 0, 32'd0, 0, 0, 0, 0);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
        tick();
        dec_valid = 1'b0; wb_we = 1'b0;
        chk("x0_guard", operandB, 32'd0);
        tick();

        // PC / immediate source selection
        set_dec(4'd8, 2, 1, 32'h55, 2, 32'h66, 32'hFFFF_FFFC, 32'h100, 1, 1);
        tick();
        dec_valid = 1'b0;
        chk("sel_opA", operandA, 32'h100);
        chk("sel_opB", operandB, 32'hFFFF_FFFC);
        chk("sel_fn", {28'd0, alu_fn}, 32'd8);
        tick();

        // flush with both entries full and an incoming instruction
        ex_ready = 1'b0;
        set_dec(1, 1, 1, 32'hA1, 2, 32'hA2, 0, 0, 0, 0); tick();
        set_dec(2, 2, 1, 32'hB1, 2, 32'hB2, 0, 0, 0, 0); tick();
        set_dec(3, 3, 1, 32'hC1, 2, 32'hC2, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0; dec_valid = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_ready", {31'd0, dec_ready}, 32'd1);
        tick();

        // asynchronous reset pulse mid-stall
        set_dec(1, 1, 1, 32'hD1, 2, 32'hD2, 0, 0, 0, 0); tick();
        set_dec(2, 2, 1, 32'hE1, 2, 32'hE2, 0, 0, 0, 0); tick();
        dec_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_ready", {31'd0, dec_ready}, 32'd1);
        chk("arst_opA", operandA, 32'd0);
        chk("arst_opB", operandB, 32'd0);
        q.delete();
        #1 reset = 1'b0;
        @(negedge clk);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_dec(4'($urandom), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                    $urandom, $urandom, 1'($urandom), 1'($urandom));
            dec_valid = ($urandom_range(0, 3) != 0);
            ex_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            wb_we     = 1'($urandom);
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            tick();
        end
        flush = 1'b0; dec_valid = 1'b0; wb_we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU; accepts decoded instructions from decode and presents operandA, operandB and alu_fn to the ALU.
- Holds up to two instructions: an output register and a skid register, with a valid/ready handshake on both sides.
- Applies writeback-to-issue operand forwarding, including snooping of buffered entries.
- Selects immediate and PC operand sources.

Parameters:
- XLEN, 32, datapath width; must match ALU operand width.
- FN_W, 4, alu_fn width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries (branch redirect).
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  stage can accept; registered, equals ~skid_valid.
- dec_alu_fn  in  FN_W  ALU function code.
- dec_rs1_addr, dec_rs2_addr  in  REG_AW  source register indices.
- dec_rs1_val, dec_rs2_val  in  XLEN  register-file read data.
- dec_rd_addr  in  REG_AW  destination register.
- dec_imm  in  XLEN  sign-extended immediate.
- dec_pc  in  XLEN  instruction PC.
- dec_use_imm  in  1  operandB = imm instead of rs2.
- dec_use_pc  in  1  operandA = pc instead of rs1.
- wb_we  in  1  writeback writes the register file this cycle.
- wb_rd  in  REG_AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- ex_valid  out  1  operands valid to the ALU/execute.
- ex_ready  in  1  execute consumes this cycle.
- operandA, operandB  out  XLEN  to the ALU.
- alu_fn  out  FN_W  to the ALU.
- ex_rd_addr  out  REG_AW  destination, passed down.

Behaviour:
- Reset (async, active-high) clears out_valid, skid_valid and all stored fields. After reset: ex_valid=0, dec_ready=1, operandA=0, operandB=0, alu_fn=0, ex_rd_addr=0.
- Handshake:
  - Accept when dec_valid & dec_ready.
  - Consume when ex_valid & ex_ready.
  - Latency: an accepted instruction appears on ex_* the next cycle when the output register is empty or being consumed.
- Entry contents: fn, rd, rs1/rs2 addr and value, imm, pc, use_imm, use_pc.
- Operand outputs are combinational from the output register:
  - operandA = use_pc ? pc : rs1_val.
  - operandB = use_imm ? imm : rs2_val.
- Capture forwarding: if wb_we and wb_rd == dec_rsN_addr and wb_rd != 0, store wb_data instead of dec_rsN_val.
- Snoop forwarding: every cycle, each valid buffered entry (output and skid) replaces its rsN_val with wb_data when wb_we and wb_rd == rsN_addr != 0. Reads of x0 are never forwarded.
- Buffer transitions, priority flush > normal:
  - Output empty or consumed, skid empty: accepted entry loads the output register.
  - Output consumed, skid full: skid moves to the output register; skid becomes empty. dec_ready was 0, so there is no accept.
  - Output full and not consumed: an accepted entry loads the skid register.
  - dec_ready registered: next dec_ready = ~next skid_valid.
- Flush: clears out_valid and skid_valid next edge. An accept in the same cycle is discarded. A consume in the same cycle completes normally (execute already sampled it).
- Simultaneous snoop and capture in the same cycle: both use the same wb_data; no conflict.
- Reset mid-operation: all entries discarded immediately; no partial outputs.
- No arithmetic beyond muxing; widths are exact, with no extension inside this block.

Optional Feature:
- Macro ISSUE_FWD_EN.
- Defined: capture and snoop forwarding as above.
- Undefined: no forwarding logic; stored values are dec_rsN_val as sampled. The wb_* ports remain but are ignored. The hazard must then be resolved by decode stalling.

Test Plan:
- Reset, then single instruction with fn=0, rs1_val=5, rs2_val=7, ex_ready=1 → next cycle ex_valid=1, operandA=5, operandB=7, alu_fn=0; dec_ready stays 1.
- ex_ready=0 with 3 back-to-back instructions (A, B, C) → A held on outputs, B in skid, dec_ready=0 the cycle after B is accepted, C not accepted. Release ex_ready → A, B, C exit in order, one per cycle.
- Forwarding at capture and snoop:
  - Capture: rs1_addr=3, dec_rs1_val=1, wb_we=1, wb_rd=3, wb_data=0xDEAD → operandA=0xDEAD.
  - Snoop: with ex_ready=0, a later wb writes x3=0xBEEF → operandA changes to 0xBEEF while stalled.
- x0 guard: rs2_addr=0, wb_rd=0, wb_we=1, wb_data=9 → operandB=dec_rs2_val (0), not 9.
- Source selection: use_pc=1, use_imm=1, pc=0x100, imm=0xFFFFFFFC, fn=8 → operandA=0x100, operandB=0xFFFFFFFC, alu_fn=8.
- Flush with both entries full plus dec_valid=1 → next cycle ex_valid=0, dec_ready=1, nothing issued. Async reset pulse mid-stall → same state immediately.
